// File: rtl/commit_cfi_stage.sv
// Commit stage with control-flow-integrity checks.
// Port 0 retires every instruction class. Higher ports retire only plain
// (class OTHER) entries, and only behind an in-order chain of acks.
// A landing-pad FSM requires that an indirect jump or call be followed by an
// LPAD instruction. A circular shadow stack holds call link addresses and
// checks them against return targets.
module commit_cfi_stage #(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int SS_DEPTH        = 16,
  parameter int VLEN            = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              halt_i,
  input  logic                              flush_i,
  input  logic                              single_step_i,
  input  logic                              cfi_en_i,
  input  logic [NR_COMMIT_PORTS-1:0]        commit_valid_i,
  input  logic [NR_COMMIT_PORTS-1:0]        commit_ex_i,
  input  logic [NR_COMMIT_PORTS*3-1:0]      commit_cls_i,
  input  logic [NR_COMMIT_PORTS*VLEN-1:0]   commit_result_i,
  input  logic                              lsu_ready_i,
  output logic [NR_COMMIT_PORTS-1:0]        commit_ack_o,
  output logic                              commit_lsu_o,
  output logic                              cfi_ex_valid_o,
  output logic [1:0]                        cfi_ex_tval_o,
  output logic [$clog2(SS_DEPTH):0]         ss_count_o,
  output logic                              ss_ovf_o
);

  localparam int PTR_W = $clog2(SS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] CLS_OTHER = 3'd0;
  localparam logic [2:0] CLS_STORE = 3'd1;
  localparam logic [2:0] CLS_CALL  = 3'd3;
  localparam logic [2:0] CLS_RET   = 3'd4;
  localparam logic [2:0] CLS_IJUMP = 3'd5;
  localparam logic [2:0] CLS_LPAD  = 3'd6;
  localparam logic [2:0] CLS_ICALL = 3'd7;

  typedef enum logic {LP_IDLE, LP_EXPECT} lp_state_e;

  lp_state_e            lp_state_q, lp_state_d;
  logic [VLEN-1:0]      ss_mem [SS_DEPTH];
  logic [PTR_W-1:0]     ss_ptr_q;
  logic [CNT_W-1:0]     ss_cnt_q;
  logic                 ss_ovf_q;

  logic [2:0]           cls0;
  logic [VLEN-1:0]      res0;
  logic [VLEN-1:0]      ss_top;
  logic                 active0;
  logic                 ss_checked;
  logic                 lp_fault;
  logic                 ss_fault;
  logic                 ack0;
  logic                 do_push;
  logic                 do_pop;
  logic                 chain_ok;

  assign cls0   = commit_cls_i[2:0];
  assign res0   = commit_result_i[VLEN-1:0];
  assign ss_top = ss_mem[ss_ptr_q - PTR_W'(1)];

  // Port-0 decode: fault detection in priority order, then the port-0 ack.
  always_comb begin
    active0    = commit_valid_i[0] && !commit_ex_i[0] && !halt_i;
    ss_checked = cfi_en_i && (ss_cnt_q != '0);
    lp_fault   = active0 && cfi_en_i && (lp_state_q == LP_EXPECT) && (cls0 != CLS_LPAD);
    ss_fault   = active0 && !lp_fault && (cls0 == CLS_RET) && ss_checked && (res0 != ss_top);
    ack0       = active0 && !lp_fault && !ss_fault && ((cls0 != CLS_STORE) || lsu_ready_i);
    do_push    = ack0 && ((cls0 == CLS_CALL) || (cls0 == CLS_ICALL));
    do_pop     = ack0 && (cls0 == CLS_RET) && ss_checked;
  end

  // In-order ack chain: a higher port retires only plain entries behind acked ports.
  always_comb begin
    commit_ack_o    = '0;
    commit_ack_o[0] = ack0;
    chain_ok        = ack0;
    for (int i = 1; i < NR_COMMIT_PORTS; i++) begin
      chain_ok = chain_ok && commit_valid_i[i] && !commit_ex_i[i] &&
                 (commit_cls_i[i*3 +: 3] == CLS_OTHER) && !single_step_i;
      commit_ack_o[i] = chain_ok;
    end
  end

  // Fault and store-commit outputs.
  always_comb begin
    commit_lsu_o   = ack0 && (cls0 == CLS_STORE);
    cfi_ex_valid_o = lp_fault || ss_fault;
    cfi_ex_tval_o  = 2'd0;
    if (lp_fault) begin
      cfi_ex_tval_o = 2'd2;
    end else if (ss_fault) begin
      cfi_ex_tval_o = 2'd3;
    end
  end

  // Landing-pad FSM next state; a flush always wins.
  always_comb begin
    lp_state_d = lp_state_q;
    if (!halt_i) begin
      if (!cfi_en_i) begin
        lp_state_d = LP_IDLE;
      end else if (ack0 && ((cls0 == CLS_IJUMP) || (cls0 == CLS_ICALL))) begin
        lp_state_d = LP_EXPECT;
      end else if (ack0 && (cls0 == CLS_LPAD)) begin
        lp_state_d = LP_IDLE;
      end
    end
    if (flush_i) begin
      lp_state_d = LP_IDLE;
    end
  end

  // Landing-pad FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lp_state_q <= LP_IDLE;
    end else begin
      lp_state_q <= lp_state_d;
    end
  end

  // Shadow-stack pointer, count and sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ss_ptr_q <= '0;
      ss_cnt_q <= '0;
      ss_ovf_q <= 1'b0;
    end else if (do_push) begin
      ss_ptr_q <= ss_ptr_q + PTR_W'(1);
      if (ss_cnt_q == CNT_W'(SS_DEPTH)) begin
        ss_ovf_q <= 1'b1;
      end else begin
        ss_cnt_q <= ss_cnt_q + CNT_W'(1);
      end
    end else if (do_pop) begin
      ss_ptr_q <= ss_ptr_q - PTR_W'(1);
      ss_cnt_q <= ss_cnt_q - CNT_W'(1);
    end
  end

  // Shadow-stack storage; a push when full overwrites the oldest slot.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      ss_mem[ss_ptr_q] <= res0;
    end
  end

  assign ss_count_o = ss_cnt_q;
  assign ss_ovf_o   = ss_ovf_q;

endmodule

// File: doc/commit_cfi_stage.md
COMMIT_CFI_STAGE -- requirements
Module: commit_cfi_stage

Interface
REQ-001 SHALL have parameter NR_COMMIT_PORTS, default 2, number of commit ports (legal 1..4).
REQ-002 SHALL have parameter SS_DEPTH, default 16, shadow-stack entries (power of 2, >=2).
REQ-003 SHALL have parameter VLEN, default 64, address width.
REQ-004 SHALL have clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have halt_i  in  1  suppresses commits, exceptions and state updates.
REQ-007 SHALL have flush_i  in  1  synchronous pipeline flush; returns the landing-pad FSM to IDLE.
REQ-008 SHALL have single_step_i  in  1  restricts commit to port 0.
REQ-009 SHALL have cfi_en_i  in  1  enables landing-pad and shadow-stack checks.
REQ-010 SHALL have commit_valid_i  in  NR_COMMIT_PORTS  per-port entry valid.
REQ-011 SHALL have commit_ex_i  in  NR_COMMIT_PORTS  per-port earlier exception pending.
REQ-012 SHALL have commit_cls_i  in  NR_COMMIT_PORTS x 3  class: 0 OTHER, 1 STORE, 2 CSR, 3 CALL, 4 RET, 5 IJUMP, 6 LPAD, 7 ICALL.
REQ-013 SHALL have commit_result_i  in  NR_COMMIT_PORTS x VLEN  link address (CALL/ICALL) or return target (RET).
REQ-014 SHALL have lsu_ready_i  in  1  store buffer can accept.
REQ-015 SHALL have commit_ack_o  out  NR_COMMIT_PORTS  entry retired this cycle.
REQ-016 SHALL have commit_lsu_o  out  1  store committed on port 0.
REQ-017 SHALL have cfi_ex_valid_o  out  1  CFI fault; cfi_ex_tval_o  out  2  (2 = landing-pad fault, 3 = shadow-stack fault); cause fixed at 18 by the controller.
REQ-018 SHALL have ss_count_o  out  $clog2(SS_DEPTH)+1  valid shadow-stack entries; ss_ovf_o  out  1  sticky overflow flag.

Function
REQ-019 Port i>0 SHALL ack only if ports 0..i-1 ack, entry valid, !commit_ex_i[i], class in {OTHER, LPAD-excluded}, i.e. class 0 only, and !single_step_i.
REQ-020 Classes 1-7 SHALL retire only on port 0; such an entry on port i>0 SHALL stall that port and all higher ports.
REQ-021 Port 0 SHALL ack when valid, !commit_ex_i[0], !halt_i, no CFI fault, and (class!=STORE or lsu_ready_i); commit_lsu_o = ack0 && class0==STORE.
REQ-022 Landing-pad FSM: states IDLE, EXPECT_LP; IDLE->EXPECT_LP on port-0 ack of IJUMP or ICALL with cfi_en_i=1.
REQ-023 In EXPECT_LP, port-0 valid LPAD without exception SHALL ack and return to IDLE; any other valid, exception-free class SHALL assert cfi_ex_valid_o, tval 2, and not ack.
REQ-024 With cfi_en_i=0, LPAD SHALL retire as a no-op and the FSM SHALL remain/return to IDLE.
REQ-025 Shadow stack: circular buffer of SS_DEPTH VLEN-bit entries; port-0 ack of CALL/ICALL SHALL push commit_result_i[0].
REQ-026 Push when full SHALL overwrite the oldest entry, keep ss_count_o = SS_DEPTH, set ss_ovf_o (cleared only by reset).
REQ-027 Port-0 RET with cfi_en_i=1 and ss_count_o>0: match with top SHALL ack and pop; mismatch SHALL assert cfi_ex_valid_o, tval 3, no ack, no pop.
REQ-028 RET with ss_count_o=0 or cfi_en_i=0 SHALL ack without check; pointers unchanged.
REQ-029 Fault priority: halt_i (none) > commit_ex_i[0] (no CFI fault, no ack) > landing-pad fault > shadow-stack fault.
REQ-030 cfi_ex_valid_o and commit_ack_o SHALL be combinational from current inputs and state (zero-cycle latency); stack and FSM update on the following edge.
REQ-031 flush_i SHALL force FSM to IDLE next cycle and SHALL NOT alter stack contents; flush_i and push in one cycle: push takes effect.
REQ-032 Pointer arithmetic SHALL wrap modulo SS_DEPTH; count saturates at SS_DEPTH and never underflows.

Reset
REQ-033 On rst_ni low, asynchronously: FSM=IDLE, stack pointer=0, ss_count_o=0, ss_ovf_o=0; outputs derived from these; stack data need not reset.
REQ-034 Reset deasserted mid-sequence SHALL lose any pending EXPECT_LP state and stack contents.

Verification
REQ-035 CALL result 0x8000_1000 on port 0, later RET result 0x8000_1000 -> both ack, ss_count_o 1 then 0, no fault.
REQ-036 CALL 0x1000 then RET 0x2000, cfi_en_i=1 -> RET not acked, cfi_ex_valid_o=1, tval 3, ss_count_o stays 1.
REQ-037 IJUMP acked, next port-0 OTHER -> no ack, cfi_ex_valid_o=1, tval 2; flush_i then FSM IDLE, OTHER acks.
REQ-038 SS_DEPTH=4: five CALLs 0x10..0x50, then five RETs 0x50..0x10 -> first four match, ss_ovf_o=1, fifth acks unchecked with count 0.
REQ-039 NR_COMMIT_PORTS=4, ports OTHER, OTHER, CALL, OTHER valid -> acks 0b0011; next cycle CALL on port 0 acks.
REQ-040 halt_i=1 with mismatching RET on port 0 -> no ack, cfi_ex_valid_o=0, state unchanged.
